// File: rtl/if_id_stage.sv
// if_id_stage: LEGv8 instruction fetch and IF/ID pipeline register.
// Holds the PC and presents it to instruction memory. Each accepted fetch is
// latched into IF/ID, and the decoder opcode is taken straight from IF/ID.
// Per-edge priority: branch flush > hazard stall > memory wait > normal fetch.
module if_id_stage #(
  parameter int unsigned                PC_WIDTH    = 64,
  parameter int unsigned                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  input  logic                   imem_valid_i,
  output logic [PC_WIDTH-1:0]    if_id_pc_o,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic                   if_id_valid_o,
  output logic [10:0]            opcode_o,
  output logic [31:0]            fetch_count_o
);

  localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4);
  // Low two bits are dropped so a misaligned RESET_PC cannot produce a misaligned fetch.
  localparam logic [PC_WIDTH-1:0] PC_RST_VAL  = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [31:0]            fetch_count_q, fetch_count_d;

  logic                   do_flush;
  logic                   do_hold;
  logic                   do_wait;
  logic                   do_fetch;
  logic [PC_WIDTH-1:0]    branch_pc;

  assign branch_pc = {branch_target_i[PC_WIDTH-1:2], 2'b00};

  // Decode which single action applies on the coming edge (first match wins).
  always_comb begin
    do_flush = 1'b0;
    do_hold  = 1'b0;
    do_wait  = 1'b0;
    do_fetch = 1'b0;
    if (branch_taken_i) begin
      do_flush = 1'b1;
    end else if (stall_i) begin
      do_hold = 1'b1;
    end else if (!imem_valid_i) begin
      do_wait = 1'b1;
    end else begin
      do_fetch = 1'b1;
    end
  end

  // Next PC: redirect on flush, advance on an accepted fetch, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (do_flush) begin
      pc_d = branch_pc;
    end else if (do_fetch) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Next IF/ID contents: bubble on flush or wait, capture on fetch, hold on stall.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (do_flush || do_wait) begin
      if_id_pc_d    = '0;
      if_id_instr_d = '0;
      if_id_valid_d = 1'b0;
    end else if (do_fetch) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_data_i;
      if_id_valid_d = 1'b1;
    end
  end

  // Fetch counter only moves when an instruction is actually accepted into IF/ID.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (do_fetch) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Program counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_RST_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Accepted-instruction counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  // do_hold is implied by the defaults above; kept as a named term for readability.
  logic unused_hold;
  assign unused_hold = do_hold;

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign fetch_count_o = fetch_count_q;
  // A bubble decodes as opcode 0 so every control line downstream stays deasserted.
  assign opcode_o      = if_id_valid_q ? if_id_instr_q[31:21] : 11'b0;

endmodule
